display_scan_controller: RTL and testbench

//  Time-multiplexed driver for the 4-digit 7-segment display. Divides i_Clk into digit slots,

---
 rtl/display_pkg.sv | 19 +
 rtl/seg7_hex_decoder.sv | 14 +
 rtl/display_scan_controller.sv | 168 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller:
// digit count, digit-index type, blank pattern and the hex glyph table.
package display_pkg;

  localparam int N_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder using the shared glyph table.
module seg7_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for the incoming hex nibble.
  always_comb begin
    seg_o = SEG_HEX[nibble_i];
  end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit 7-segment driver: prescaler-timed digit ring,
// PWM brightness, frame-aligned double buffering of the display value.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits
// 3..1; digit 0 always shown). Default build shows every digit's hex glyph.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIM_W    = 3
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_En,
  input  logic [DIM_W-1:0]    i_Bright,
  input  logic                i_Load,
  input  logic [15:0]         i_Data,
  output logic [N_DIGITS-1:0] o_Anodo,
  output logic [1:0]          o_Sel,
  output logic [6:0]          o_Seg,
  output logic                o_Pend,
  output logic                o_Frame
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

  // Scan state
  logic [PRESC_W-1:0]  presc_q, presc_d;
  digit_idx_t          idx_q, idx_d;
  logic [DIM_W-1:0]    pwm_q, pwm_d;

  // Double-buffered display value
  logic [15:0]         disp_q, disp_d;
  logic [15:0]         pend_buf_q, pend_buf_d;
  logic                pend_q, pend_d;

  // Output registers
  logic [N_DIGITS-1:0] anodo_q, anodo_d;
  logic [1:0]          sel_q, sel_d;
  logic [6:0]          seg_q, seg_d;
  logic                frame_q, frame_d;

  // Combinational helpers
  logic                tick_s;
  logic                boundary_s;
  logic                blank_s;
  logic [3:0]          nibble_s;
  logic [6:0]          glyph_s;

  seg7_hex_decoder u_dec (
    .nibble_i (nibble_s),
    .seg_o    (glyph_s)
  );

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    nibble_s = 4'h0;
    case (idx_q)
      2'd0:    nibble_s = disp_q[3:0];
      2'd1:    nibble_s = disp_q[7:4];
      2'd2:    nibble_s = disp_q[11:8];
      2'd3:    nibble_s = disp_q[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every higher digit are zero; digit 0 always lit.
  always_comb begin
    blank_s = 1'b0;
    case (idx_q)
      2'd0:    blank_s = 1'b0;
      2'd1:    blank_s = (disp_q[15:4] == 12'h000);
      2'd2:    blank_s = (disp_q[15:8] == 8'h00);
      2'd3:    blank_s = (disp_q[15:12] == 4'h0);
      default: blank_s = 1'b0;
    endcase
  end
`else
  // Leading-zero blanking not built: every digit shows its glyph.
  always_comb begin
    blank_s = 1'b0;
  end
`endif

  // Next-state for prescaler, digit ring, PWM counter and display buffers.
  always_comb begin
    tick_s     = (presc_q == PRESC_LAST);
    boundary_s = tick_s && (idx_q == 2'd3);

    if (tick_s) begin
      presc_d = PRESC_W'(0);
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
      idx_d   = idx_q;
    end

    pwm_d = pwm_q + DIM_W'(1);

    disp_d     = disp_q;
    pend_buf_d = pend_buf_q;
    pend_d     = pend_q;
    // A load on the boundary cycle bypasses the pending buffer entirely.
    if (i_Load && boundary_s) begin
      disp_d = i_Data;
      pend_d = 1'b0;
    end else if (i_Load) begin
      pend_buf_d = i_Data;
      pend_d     = 1'b1;
    end else if (boundary_s && pend_q) begin
      disp_d = pend_buf_q;
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Next values of the registered pin outputs.
  always_comb begin
    sel_d = idx_q;
    if (i_En && (pwm_q <= i_Bright)) begin
      anodo_d = N_DIGITS'(4'b0001 << idx_q);
    end else begin
      anodo_d = {N_DIGITS{1'b0}};
    end
    if (i_En && !blank_s) begin
      seg_d = glyph_s;
    end else begin
      seg_d = SEG_BLANK;
    end
    frame_d = boundary_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      presc_q    <= PRESC_W'(0);
      idx_q      <= 2'd0;
      pwm_q      <= DIM_W'(0);
      disp_q     <= 16'h0000;
      pend_buf_q <= 16'h0000;
      pend_q     <= 1'b0;
      anodo_q    <= {N_DIGITS{1'b0}};
      sel_q      <= 2'd0;
      seg_q      <= 7'h00;
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_d;
      disp_q     <= disp_d;
      pend_buf_q <= pend_buf_d;
      pend_q     <= pend_d;
      anodo_q    <= anodo_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      frame_q    <= frame_d;
    end
  end

  assign o_Anodo = anodo_q;
  assign o_Sel   = sel_q;
  assign o_Seg   = seg_q;
  assign o_Pend  = pend_q;
  assign o_Frame = frame_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (SCAN_DIV=4, DIM_W=3).
// Reference model derives scan position from elapsed cycles since reset.
module tb_display_scan_controller;

  localparam int SCAN_DIV = 4;
  localparam int DIM_W    = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int PWM_MOD  = 1 << DIM_W;

  logic             i_Clk;
  logic             i_Rst;
  logic             i_En;
  logic [DIM_W-1:0] i_Bright;
  logic             i_Load;
  logic [15:0]      i_Data;
  logic [3:0]       o_Anodo;
  logic [1:0]       o_Sel;
  logic [6:0]       o_Seg;
  logic             o_Pend;
  logic             o_Frame;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_buf;
  logic        m_pend;

  display_scan_controller #(.SCAN_DIV(SCAN_DIV), .DIM_W(DIM_W)) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_En     (i_En),
    .i_Bright (i_Bright),
    .i_Load   (i_Load),
    .i_Data   (i_Data),
    .o_Anodo  (o_Anodo),
    .o_Sel    (o_Sel),
    .o_Seg    (o_Seg),
    .o_Pend   (o_Pend),
    .o_Frame  (o_Frame)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic m_blank(input logic [15:0] d, input int n);
`ifdef LEADING_ZERO_BLANK_EN
    return (n != 0) && ((d >> (4 * n)) == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: apply inputs, advance model, compare every output.
  task automatic step(input logic rst, input logic en, input logic [DIM_W-1:0] bright,
                      input logic load, input logic [15:0] data);
    int          idx;
    int          pwm;
    logic        bnd;
    logic [3:0]  e_an;
    logic [1:0]  e_sel;
    logic [6:0]  e_seg;
    logic        e_frame;
    logic [3:0]  nib;
    i_Rst = rst; i_En = en; i_Bright = bright; i_Load = load; i_Data = data;
    @(posedge i_Clk);
    #1;
    if (rst) begin
      e_an = 4'b0000; e_sel = 2'd0; e_seg = 7'h00; e_frame = 1'b0;
      m_t = 0; m_disp = 16'h0000; m_buf = 16'h0000; m_pend = 1'b0;
    end else begin
      idx = (m_t / SCAN_DIV) % 4;
      pwm = m_t % PWM_MOD;
      bnd = ((m_t % FRAME) == FRAME - 1);
      nib = 4'((m_disp >> (4 * idx)) & 16'h000F);
      e_sel   = 2'(idx);
      e_an    = (en && (pwm <= int'(bright))) ? 4'(1 << idx) : 4'b0000;
      e_seg   = (en && !m_blank(m_disp, idx)) ? hex_glyph(nib) : 7'h00;
      e_frame = bnd;
      if (load && bnd) begin
        m_disp = data; m_pend = 1'b0;
      end else if (load) begin
        m_buf = data; m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        m_disp = m_buf; m_pend = 1'b0;
      end
      m_t++;
    end
    check("anodo", 16'(o_Anodo), 16'(e_an));
    check("sel",   16'(o_Sel),   16'(e_sel));
    check("seg",   16'(o_Seg),   16'(e_seg));
    check("frame", 16'(o_Frame), 16'(e_frame));
    check("pend",  16'(o_Pend),  16'(m_pend));
  endtask

  task automatic idle(input int n, input logic en, input logic [DIM_W-1:0] bright);
    for (int i = 0; i < n; i++) step(1'b0, en, bright, 1'b0, 16'h0000);
  endtask

  initial begin
    int cnt;
    i_Rst = 1'b1; i_En = 1'b0; i_Bright = '0; i_Load = 1'b0; i_Data = 16'h0000;
    m_t = 0; m_disp = 16'h0000; m_buf = 16'h0000; m_pend = 1'b0;

    // Reset, then a pending load aborted by a mid-frame reset
    step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000);
    idle(5, 1'b1, 3'd7);
    step(1'b0, 1'b1, 3'd7, 1'b1, 16'h9876);
    idle(2, 1'b1, 3'd7);
    step(1'b1, 1'b1, 3'd7, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 3'd7, 1'b0, 16'h0000);
    check("post_rst_pend", 16'(o_Pend), 16'h0000);
    idle(20, 1'b1, 3'd7);

    // Full-brightness scan of 1234
    step(1'b0, 1'b1, 3'd7, 1'b1, 16'h1234);
    idle(40, 1'b1, 3'd7);

    // Tear-free update mid digit 1
    while ((m_t % FRAME) != SCAN_DIV + 1) step(1'b0, 1'b1, 3'd7, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 3'd7, 1'b1, 16'hABCD);
    check("tearfree_pend", 16'(o_Pend), 16'h0001);
    idle(20, 1'b1, 3'd7);

    // Coincident load on the boundary cycle
    while ((m_t % FRAME) != FRAME - 1) step(1'b0, 1'b1, 3'd7, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 3'd7, 1'b1, 16'h5A3C);
    check("coinc_pend", 16'(o_Pend), 16'h0000);
    idle(3, 1'b1, 3'd7);
    // Back-to-back loads: last wins
    step(1'b0, 1'b1, 3'd7, 1'b1, 16'h1111);
    step(1'b0, 1'b1, 3'd7, 1'b1, 16'h2222);
    step(1'b0, 1'b1, 3'd7, 1'b1, 16'hE0F7);
    idle(24, 1'b1, 3'd7);

    // Brightness 1: anode on 2 of every 8 cycles
    idle(8, 1'b1, 3'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'd1, 1'b0, 16'h0000);
      if (o_Anodo != 4'b0000) cnt++;
    end
    check("duty_b1", 16'(cnt), 16'd2);
    idle(16, 1'b0, 3'd7);

    // Leading-zero pattern
    step(1'b0, 1'b1, 3'd7, 1'b1, 16'h0050);
    idle(36, 1'b1, 3'd7);

    // Randomized traffic
    for (int i = 0; i < 1200; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
           DIM_W'($urandom_range(0, PWM_MOD - 1)), ($urandom_range(0, 7) == 0),
           16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
